conv2_maxpool_relu: RTL and testbench



---
 rtl/conv2_maxpool_relu.sv | 101 ++++++++++
 tb/tb_conv2_maxpool_relu.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv2_maxpool_relu.sv
// ReLU followed by 2x2 stride-2 max pooling over a row-major conv2 feature map.
// Pooled maxima are saturated to the signed OUT_W range (always non-negative).
module conv2_maxpool_relu #(
    parameter int DATA_W  = 14,
    parameter int OUT_W   = 12,
    parameter int IN_COLS = 8,
    parameter int IN_ROWS = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] conv_in,
    output logic [OUT_W-1:0]  pool_out,
    output logic              valid_out,
    output logic              frame_done
);

    localparam int CW = (IN_COLS > 1) ? $clog2(IN_COLS) : 1;
    localparam int RW = (IN_ROWS > 1) ? $clog2(IN_ROWS) : 1;
    localparam int BW = (IN_COLS > 2) ? $clog2(IN_COLS / 2) : 1;
    localparam logic [DATA_W-1:0] SAT_MAX = DATA_W'((1 << (OUT_W - 1)) - 1);

    logic [CW-1:0]     r_colCnt;
    logic [RW-1:0]     r_rowCnt;
    logic [DATA_W-1:0] r_pair;
    logic [DATA_W-1:0] r_lineBuf [IN_COLS/2];
    logic [OUT_W-1:0]  r_poolOut;
    logic              r_validOut;
    logic              r_frameDone;

    logic [DATA_W-1:0] w_relu;
    logic [DATA_W-1:0] w_pairMax;
    logic [DATA_W-1:0] w_winMax;
    logic [BW-1:0]     w_bufIdx;
    logic              w_lastCol;
    logic              w_lastRow;
    logic              w_colOdd;
    logic              w_rowOdd;

    assign w_relu    = conv_in[DATA_W-1] ? '0 : conv_in;
    assign w_lastCol = (r_colCnt == CW'(IN_COLS - 1));
    assign w_lastRow = (r_rowCnt == RW'(IN_ROWS - 1));
    assign w_colOdd  = r_colCnt[0];
    assign w_rowOdd  = r_rowCnt[0];
    assign w_bufIdx  = BW'(r_colCnt >> 1);

    // Both operands are already non-negative after ReLU, so an unsigned compare is exact.
    assign w_pairMax = (w_relu > r_pair) ? w_relu : r_pair;
    assign w_winMax  = (r_lineBuf[w_bufIdx] > w_pairMax) ? r_lineBuf[w_bufIdx] : w_pairMax;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_colCnt <= '0;
            r_rowCnt <= '0;
        end else if (valid_in) begin
            if (w_lastCol) begin
                r_colCnt <= '0;
                r_rowCnt <= w_lastRow ? '0 : r_rowCnt + 1'b1;
            end else begin
                r_colCnt <= r_colCnt + 1'b1;
            end
        end
    end

    // Even rows park each horizontal pair maximum; odd rows consume it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pair <= '0;
            for (int i = 0; i < IN_COLS / 2; i++) begin
                r_lineBuf[i] <= '0;
            end
        end else if (valid_in) begin
            if (!w_colOdd) begin
                r_pair <= w_relu;
            end else if (!w_rowOdd) begin
                r_lineBuf[w_bufIdx] <= w_pairMax;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_poolOut   <= '0;
            r_validOut  <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_validOut  <= 1'b0;
            r_frameDone <= 1'b0;
            if (valid_in && w_colOdd && w_rowOdd) begin
                r_poolOut   <= (w_winMax > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : w_winMax[OUT_W-1:0];
                r_validOut  <= 1'b1;
                r_frameDone <= w_lastCol && w_lastRow;
            end
        end
    end

    assign pool_out   = r_poolOut;
    assign valid_out  = r_validOut;
    assign frame_done = r_frameDone;

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// Scoreboard bench for conv2_maxpool_relu: stimulus queues expected pooled values
// with their arrival cycle, and a negedge monitor checks every strobe against them.
module tb_conv2_maxpool_relu;

    typedef struct {
        logic [11:0] val;
        logic        done;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [13:0] conv_in;
    logic [11:0] pool_out;
    logic        valid_out;
    logic        frame_done;

    exp_t        expQ[$];
    int          cycleCnt;
    bit          rstAtEdge;
    logic [11:0] lastVal;
    int          total;
    int          bad;

    conv2_maxpool_relu #(
        .DATA_W(14), .OUT_W(12), .IN_COLS(8), .IN_ROWS(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .valid_in(valid_in),
        .conv_in(conv_in),
        .pool_out(pool_out),
        .valid_out(valid_out),
        .frame_done(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycleCnt  <= cycleCnt + 1;
        rstAtEdge <= rst;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cycleCnt);
        end
    endtask

    // Monitor: pops the scoreboard on each strobe, and otherwise insists pool_out holds.
    always @(negedge clk) begin
        if (rstAtEdge) lastVal = '0;
        while (expQ.size() > 0 && expQ[0].cyc < cycleCnt) begin
            total++;
            bad++;
            $display("[TB] FAIL missingStrobe actual=none required=%0d at cycle %0d", expQ[0].val, expQ[0].cyc);
            void'(expQ.pop_front());
        end
        if (valid_out === 1'b1) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spuriousStrobe actual=%0d required=no strobe (cycle %0d)", pool_out, cycleCnt);
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput("poolValue", 32'(pool_out), 32'(e.val));
                checkOutput("frameDone", 32'(frame_done), 32'(e.done));
                checkOutput("strobeCycle", 32'(cycleCnt), 32'(e.cyc));
            end
            lastVal = pool_out;
        end else begin
            checkOutput("frameDoneIdle", 32'(frame_done), 32'd0);
            checkOutput("poolHold", 32'(pool_out), 32'(lastVal));
        end
    end

    task automatic applyStimulus(input logic [13:0] v, input bit expOut,
                                 input logic [11:0] expVal, input bit expDone);
        exp_t e;
        @(posedge clk);
        #1;
        valid_in = 1'b1;
        conv_in  = v;
        if (expOut) begin
            e.val  = expVal;
            e.done = expDone;
            e.cyc  = cycleCnt + 1;
            expQ.push_back(e);
        end
    endtask

    task automatic applyIdle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
            conv_in  = 14'h2AAA;
        end
    endtask

    // mode 0: ramp+offset, 1: all -256, 2: one saturating window in a field of 7s.
    task automatic sendFrame(input int mode, input int offset, input bit gaps, input int count);
        int          idx;
        logic [13:0] v;
        logic [11:0] ev;
        bit          q;
        idx = 0;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                if (idx < count) begin
                    q = (r % 2 == 1) && (c % 2 == 1);
                    case (mode)
                        0: begin
                            v  = 14'(r * 8 + c + offset);
                            ev = 12'(r * 8 + c + offset);
                        end
                        1: begin
                            v  = 14'h3F00;
                            ev = 12'd0;
                        end
                        default: begin
                            if (r == 2 && c == 4) v = 14'h1388;
                            else if ((r == 2 || r == 3) && (c == 4 || c == 5)) v = 14'd100;
                            else v = 14'd7;
                            ev = (r == 3 && c == 5) ? 12'd2047 : 12'd7;
                        end
                    endcase
                    applyStimulus(v, q, ev, (r == 7) && (c == 7));
                    if (gaps) applyIdle(1);
                end
                idx++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        cycleCnt  = 0;
        rstAtEdge = 1'b1;
        lastVal   = '0;
        rst       = 1'b1;
        valid_in  = 1'b0;
        conv_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("resetPool", 32'(pool_out), 32'd0);
        checkOutput("resetValid", 32'(valid_out), 32'd0);
        checkOutput("resetDone", 32'(frame_done), 32'd0);

        $display("[TB] ramp frame");
        sendFrame(0, 0, 1'b0, 64);
        applyIdle(4);

        $display("[TB] all-negative frame");
        sendFrame(1, 0, 1'b0, 64);
        applyIdle(4);

        $display("[TB] saturation frame");
        sendFrame(2, 0, 1'b0, 64);
        applyIdle(4);

        $display("[TB] ramp with gaps");
        sendFrame(0, 0, 1'b1, 64);
        applyIdle(4);

        $display("[TB] mid-frame reset");
        sendFrame(0, 0, 1'b0, 30);
        @(posedge clk);
        #1;
        rst      = 1'b1;
        valid_in = 1'b1;
        conv_in  = 14'd1234;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        valid_in = 1'b0;
        sendFrame(0, 0, 1'b0, 64);
        applyIdle(4);

        $display("[TB] back-to-back frames");
        sendFrame(0, 0, 1'b0, 64);
        sendFrame(0, 100, 1'b0, 64);
        applyIdle(6);

        @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
